// File: rtl/dmem_pkg.sv
// Shared data-memory definitions: load/store funct3 codes, cache FSM state
// encoding, block geometry and the store byte-merge helper.
package dmem_pkg;

    // Load funct3 codes (DMEM_READ[2:0])
    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    // Store funct3[1:0] codes (DMEM_WRITE[1:0])
    localparam logic [1:0] STORE_SB = 2'b00;
    localparam logic [1:0] STORE_SH = 2'b01;
    localparam logic [1:0] STORE_SW = 2'b10;

    // Cache controller FSM encoding
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITEBACK = 2'd1;
    localparam logic [1:0] ST_ALLOCATE  = 2'd2;
    localparam logic [1:0] ST_UPDATE    = 2'd3;

    // Block geometry: one memory beat carries a whole line
    localparam int BLOCK_BYTES = 16;
    localparam int BLOCK_BITS  = BLOCK_BYTES * 8;

    // Merge store data into the addressed word. Misaligned low address bits
    // are dropped: SH uses only off[1], SW ignores off entirely.
    function automatic logic [31:0] store_merge(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [1:0]  off,
        input logic [1:0]  size
    );
        logic [31:0] w;
        w = old_word;
        case (size)
            STORE_SB: w[{off, 3'b000} +: 8]        = wdata[7:0];
            STORE_SH: w[{off[1], 4'b0000} +: 16]   = wdata[15:0];
            default:  w                            = wdata;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/dcache_load_formatter.sv
// Load result formatter: selects the byte/halfword/word of the addressed
// cache word and sign- or zero-extends it to 32 bits.
module dcache_load_formatter
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Lane select then extension; LH ignores offset[0], LW ignores both bits
    always_comb begin
        byte_val = word[{offset, 3'b000} +: 8];
        half_val = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            LOAD_LB:  result = {{24{byte_val[7]}}, byte_val};
            LOAD_LH:  result = {{16{half_val[15]}}, half_val};
            LOAD_LBU: result = {24'b0, byte_val};
            LOAD_LHU: result = {16'b0, half_val};
            default:  result = word;
        endcase
    end

endmodule

// File: rtl/dcache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache with a block-wide
// backing memory port.
//
// CPU handshake: a request (DMEM_READ[3] or DMEM_WRITE[2]) is accepted in the
// first cycle BUSYWAIT is low; until then the requester holds address, data
// and enables stable. Memory handshake: MEM_READ/MEM_WRITE stay high for the
// whole transaction and the transaction completes in the first cycle
// MEM_BUSYWAIT is low.
module dcache_dm_wb
    import dmem_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int IDX_W     = 3,
    parameter int TAG_W     = 32 - 4 - IDX_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [31:0]           DMEM_ADDR,
    input  logic [31:0]           DMEM_WDATA,
    input  logic [3:0]            DMEM_READ,
    input  logic [2:0]            DMEM_WRITE,
    output logic [31:0]           DMEM_RDATA,
    output logic                  BUSYWAIT,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [27:0]           MEM_ADDR,
    output logic [BLOCK_BITS-1:0] MEM_WDATA,
    input  logic [BLOCK_BITS-1:0] MEM_RDATA,
    input  logic                  MEM_BUSYWAIT
);

    logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
    logic [BLOCK_BITS-1:0] data_mem [NUM_LINES];
    logic [NUM_LINES-1:0]  valid_bits;
    logic [NUM_LINES-1:0]  dirty_bits;

    logic [1:0] state;
    logic [1:0] next_state;

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      addr_tag;
    logic [6:0]            word_sel;
    logic [BLOCK_BITS-1:0] line;
    logic [BLOCK_BITS-1:0] merged_line;
    logic [31:0]           cur_word;
    logic [31:0]           load_result;
    logic                  load_en;
    logic                  store_en;
    logic                  req;
    logic                  hit;
    logic                  lookup_ok;
    logic                  store_commit;

    assign idx      = DMEM_ADDR[4 +: IDX_W];
    assign addr_tag = DMEM_ADDR[31 -: TAG_W];
    assign word_sel = {DMEM_ADDR[3:2], 5'b00000};
    assign load_en  = DMEM_READ[3];
    assign store_en = DMEM_WRITE[2];
    assign req      = load_en | store_en;
    assign line     = data_mem[idx];
    assign cur_word = line[word_sel +: 32];

    assign hit          = valid_bits[idx] && (tag_mem[idx] == addr_tag);
    // A lookup only completes from IDLE; while reset is asserted nothing completes
    assign lookup_ok    = RST && (state == ST_IDLE) && hit;
    // Store wins when both enables are set
    assign store_commit = lookup_ok && store_en;

    dcache_load_formatter u_fmt (
        .word   (cur_word),
        .offset (DMEM_ADDR[1:0]),
        .funct3 (DMEM_READ[2:0]),
        .result (load_result)
    );

    // CPU-side outputs: zero-latency hit data and stall on any unfinished request
    always_comb begin
        BUSYWAIT   = RST && req && !lookup_ok;
        DMEM_RDATA = (lookup_ok && load_en && !store_en) ? load_result : 32'b0;
    end

    // Line image with the store bytes merged into the addressed word
    always_comb begin
        merged_line = line;
        merged_line[word_sel +: 32] = store_merge(cur_word, DMEM_WDATA,
                                                  DMEM_ADDR[1:0], DMEM_WRITE[1:0]);
    end

    // Next-state logic for the miss handler
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (req && !hit)
                    next_state = (valid_bits[idx] && dirty_bits[idx]) ? ST_WRITEBACK
                                                                       : ST_ALLOCATE;
            end
            ST_WRITEBACK: if (!MEM_BUSYWAIT) next_state = ST_ALLOCATE;
            ST_ALLOCATE:  if (!MEM_BUSYWAIT) next_state = ST_UPDATE;
            default:      next_state = ST_IDLE;
        endcase
    end

    // Memory-side outputs decoded from state; write-back uses the victim's tag
    always_comb begin
        MEM_READ  = (state == ST_ALLOCATE);
        MEM_WRITE = (state == ST_WRITEBACK);
        MEM_ADDR  = 28'b0;
        MEM_WDATA = '0;
        if (state == ST_WRITEBACK) begin
            MEM_ADDR  = {tag_mem[idx], idx};
            MEM_WDATA = line;
        end else if (state == ST_ALLOCATE) begin
            MEM_ADDR  = DMEM_ADDR[31:4];
        end
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (!RST) state <= ST_IDLE;
        else      state <= next_state;
    end

    // Valid/dirty bookkeeping: refill installs a clean line, store hit dirties it
    always_ff @(posedge CLK) begin
        if (!RST) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (state == ST_UPDATE) begin
            valid_bits[idx] <= 1'b1;
            dirty_bits[idx] <= 1'b0;
        end else if (store_commit) begin
            dirty_bits[idx] <= 1'b1;
        end
    end

    // Data/tag arrays: refill write or store merge; reset blocks a pending refill
    always_ff @(posedge CLK) begin
        if (RST) begin
            if (state == ST_UPDATE) begin
                data_mem[idx] <= MEM_RDATA;
                tag_mem[idx]  <= addr_tag;
            end else if (store_commit) begin
                data_mem[idx] <= merged_line;
            end
        end
    end

endmodule

// File: tb/tb_dcache_dm_wb.sv
// Self-checking bench for dcache_dm_wb. The reference is a flat byte-addressed
// view of memory as the CPU sees it plus a record of which block each index
// holds; a block-wide backing memory with a fixed busy time answers the
// cache's refill and write-back requests.
module tb_dcache_dm_wb;

  localparam int MEM_LAT = 3;
  localparam logic [3:0] RD_NONE = 4'b0000;
  localparam logic [3:0] RD_LB   = 4'b1000;
  localparam logic [3:0] RD_LH   = 4'b1001;
  localparam logic [3:0] RD_LW   = 4'b1010;
  localparam logic [3:0] RD_LBU  = 4'b1100;
  localparam logic [3:0] RD_LHU  = 4'b1101;
  localparam logic [2:0] WR_NONE = 3'b000;
  localparam logic [2:0] WR_SB   = 3'b100;
  localparam logic [2:0] WR_SH   = 3'b101;
  localparam logic [2:0] WR_SW   = 3'b110;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b0;
  logic [31:0]  dmem_addr = '0;
  logic [31:0]  dmem_wdata = '0;
  logic [3:0]   dmem_read = '0;
  logic [2:0]   dmem_write = '0;
  logic [31:0]  dmem_rdata;
  logic         busywait;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_busy = 1'b0;

  dcache_dm_wb dut (
    .CLK          (clk),
    .RST          (rst),
    .DMEM_ADDR    (dmem_addr),
    .DMEM_WDATA   (dmem_wdata),
    .DMEM_READ    (dmem_read),
    .DMEM_WRITE   (dmem_write),
    .DMEM_RDATA   (dmem_rdata),
    .BUSYWAIT     (busywait),
    .MEM_READ     (mem_read),
    .MEM_WRITE    (mem_write),
    .MEM_ADDR     (mem_addr),
    .MEM_WDATA    (mem_wdata),
    .MEM_RDATA    (mem_rdata),
    .MEM_BUSYWAIT (mem_busy)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int fails  = 0;

  logic [127:0] phys_blk [64];   // backing memory, block granular
  logic [7:0]   arch_mem [1024]; // memory as the CPU should observe it
  bit           res_valid [8];
  bit           res_dirty [8];
  int           res_blk   [8];

  logic [27:0]  exp_rd_q[$];
  logic [27:0]  exp_wb_addr_q[$];
  logic [127:0] exp_q[$];        // expected write-back blocks
  logic [27:0]  rd_log[$];
  logic [27:0]  wb_log_addr[$];
  logic [127:0] wb_log_data[$];
  int n_reads  = 0;
  int n_writes = 0;
  bit mem_active = 1'b0;
  bit mem_is_write = 1'b0;
  int mem_cnt = 0;

  logic [2:0] load_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
    int b;
    logic [31:0] w;
    b = int'(a[9:0]);
    case (f3)
      3'b000: w = {{24{arch_mem[b][7]}}, arch_mem[b]};
      3'b100: w = {24'b0, arch_mem[b]};
      3'b001: begin b = b - (b % 2); w = {{16{arch_mem[b+1][7]}}, arch_mem[b+1], arch_mem[b]}; end
      3'b101: begin b = b - (b % 2); w = {16'b0, arch_mem[b+1], arch_mem[b]}; end
      default: begin
        b = b - (b % 4);
        w = {arch_mem[b+3], arch_mem[b+2], arch_mem[b+1], arch_mem[b]};
      end
    endcase
    return w;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int b;
    b = int'(a[9:0]);
    case (sz)
      2'b00: arch_mem[b] = d[7:0];
      2'b01: begin b = b - (b % 2); arch_mem[b] = d[7:0]; arch_mem[b+1] = d[15:8]; end
      default: begin
        b = b - (b % 4);
        for (int k = 0; k < 4; k++) arch_mem[b+k] = d[8*k +: 8];
      end
    endcase
  endtask

  function automatic logic [127:0] block_of(input int blk);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = arch_mem[blk*16 + k];
    return r;
  endfunction

  task automatic set_block(input int blk, input logic [127:0] v);
    phys_blk[blk] = v;
    for (int k = 0; k < 16; k++) arch_mem[blk*16 + k] = v[8*k +: 8];
  endtask

  // ---------------- backing memory ----------------
  always @(negedge clk) begin
    if (mem_read || mem_write) begin
      check("mem_rw_exclusive", 128'(mem_read & mem_write), 128'(0));
      if (!mem_active) begin
        mem_active = 1'b1;
        mem_is_write = mem_write;
        mem_cnt = MEM_LAT;
        mem_busy = 1'b1;
        if (mem_write) begin
          wb_log_addr.push_back(mem_addr);
          wb_log_data.push_back(mem_wdata);
          if (exp_wb_addr_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_writeback: got addr %0h expected none", mem_addr);
          end else begin
            check("writeback_addr", 128'(mem_addr), 128'(exp_wb_addr_q.pop_front()));
            check("writeback_data", mem_wdata, exp_q.pop_front());
          end
        end else begin
          rd_log.push_back(mem_addr);
          if (exp_rd_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_refill: got addr %0h expected none", mem_addr);
          end else begin
            check("refill_addr", 128'(mem_addr), 128'(exp_rd_q.pop_front()));
          end
        end
      end else begin
        check("mem_request_kind_held", 128'(mem_write), 128'(mem_is_write));
        mem_cnt--;
        if (mem_cnt == 0) begin
          if (mem_is_write) begin
            phys_blk[mem_addr[5:0]] = mem_wdata;
            n_writes++;
          end else begin
            mem_rdata = phys_blk[mem_addr[5:0]];
            n_reads++;
          end
          mem_busy = 1'b0;
          mem_active = 1'b0;
        end
      end
    end else begin
      mem_active = 1'b0;
      mem_busy = 1'b0;
    end
  end

  // ---------------- driver ----------------
  // Presents one request, waits for BUSYWAIT to drop, checks result and traffic.
  task automatic do_access(input logic [31:0] a, input logic [3:0] rd, input logic [2:0] wr,
                           input logic [31:0] wd, output logic [31:0] got, output int busy_cycles);
    int blk, idx, rr0, ww0;
    bit is_store, is_load, req, miss;
    logic [31:0] exp;
    blk = int'(a[31:4]);
    idx = blk % 8;
    is_store = wr[2];
    is_load  = rd[3] && !wr[2];
    req      = rd[3] || wr[2];
    miss     = req && !(res_valid[idx] && res_blk[idx] == blk);
    if (miss) begin
      if (res_valid[idx] && res_dirty[idx]) begin
        exp_wb_addr_q.push_back(28'(res_blk[idx]));
        exp_q.push_back(block_of(res_blk[idx]));
      end
      exp_rd_q.push_back(28'(blk));
    end
    rr0 = n_reads;
    ww0 = n_writes;
    @(negedge clk);
    dmem_addr = a; dmem_read = rd; dmem_write = wr; dmem_wdata = wd;
    #1;
    check("first_cycle_busywait", 128'(busywait), 128'(miss));
    busy_cycles = 0;
    while (busywait === 1'b1 && busy_cycles < 200) begin
      busy_cycles++;
      @(negedge clk);
      #1;
    end
    check("busywait_release", 128'(busywait), 128'(0));
    got = dmem_rdata;
    exp = is_load ? model_load(a, rd[2:0]) : 32'b0;
    check("load_data", 128'(got), 128'(exp));
    check("refill_count", 128'(n_reads - rr0), 128'(miss ? 1 : 0));
    check("writeback_count", 128'(n_writes - ww0),
          128'((miss && res_valid[idx] && res_dirty[idx]) ? 1 : 0));
    if (is_store) model_store(a, wr[1:0], wd);
    if (miss) begin
      res_valid[idx] = 1'b1;
      res_blk[idx]   = blk;
      res_dirty[idx] = 1'b0;
    end
    if (is_store) res_dirty[idx] = 1'b1;
  endtask

  task automatic go_idle();
    @(negedge clk);
    dmem_read = RD_NONE; dmem_write = WR_NONE;
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  rd;
    logic [2:0]  wr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  initial begin
    logic [31:0] got;
    int bc, rd0, wr0, vb;
    bit found;
    int prev_blk [8];
    bit prev_valid [8];
    logic [31:0] va;

    // Block layout: byte at block offset k lives in bits [8k+7:8k]
    vecs[0]  = '{32'h44, RD_LW,   WR_NONE, 32'h0,        32'h00112233};
    vecs[1]  = '{32'h4F, RD_LB,   WR_NONE, 32'h0,        32'hFFFFFF88};
    vecs[2]  = '{32'h4F, RD_LBU,  WR_NONE, 32'h0,        32'h00000088};
    vecs[3]  = '{32'h4A, RD_LH,   WR_NONE, 32'h0,        32'hFFFFCCDD};
    vecs[4]  = '{32'h4A, RD_LHU,  WR_NONE, 32'h0,        32'h0000CCDD};
    vecs[5]  = '{32'h4C, RD_LW,   WR_NONE, 32'h0,        32'h8899AABB};
    vecs[6]  = '{32'h40, RD_LB,   WR_NONE, 32'h0,        32'h00000077};
    vecs[7]  = '{32'h47, RD_LW,   WR_NONE, 32'h0,        32'h00112233};
    vecs[8]  = '{32'h4B, RD_LH,   WR_NONE, 32'h0,        32'hFFFFCCDD};
    vecs[9]  = '{32'h46, RD_NONE, WR_SH,   32'h1234ABCD, 32'h0};
    vecs[10] = '{32'h44, RD_LW,   WR_NONE, 32'h0,        32'hABCD2233};
    vecs[11] = '{32'h41, RD_NONE, WR_SB,   32'h0000005A, 32'h0};
    vecs[12] = '{32'h40, RD_LW,   WR_NONE, 32'h0,        32'h44555A77};
    vecs[13] = '{32'h4E, RD_NONE, WR_SW,   32'hDEADBEEF, 32'h0};
    vecs[14] = '{32'h4C, RD_LW,   WR_NONE, 32'h0,        32'hDEADBEEF};
    vecs[15] = '{32'h48, RD_LW,   WR_SW,   32'h01020304, 32'h0};
    vecs[16] = '{32'h48, RD_LW,   WR_NONE, 32'h0,        32'h01020304};
    vecs[17] = '{32'h44, RD_NONE, WR_NONE, 32'h0,        32'h0};
    vecs[18] = '{32'h42, RD_LH,   WR_NONE, 32'h0,        32'h00004455};
    vecs[19] = '{32'h42, RD_LB,   WR_NONE, 32'h0,        32'h00000055};
    vecs[20] = '{32'h46, RD_LHU,  WR_NONE, 32'h0,        32'h0000ABCD};
    vecs[21] = '{32'h46, RD_LH,   WR_NONE, 32'h0,        32'hFFFFABCD};

    for (int b = 0; b < 64; b++) set_block(b, {$urandom, $urandom, $urandom, $urandom});
    set_block(4, 128'h8899AABB_CCDDEEFF_00112233_44556677);
    for (int i = 0; i < 8; i++) begin res_valid[i] = 1'b0; res_dirty[i] = 1'b0; res_blk[i] = 0; end

    // Reset held for two cycles
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("reset_busywait",  128'(busywait),   128'(0));
    check("reset_mem_read",  128'(mem_read),   128'(0));
    check("reset_mem_write", 128'(mem_write),  128'(0));
    check("reset_mem_addr",  128'(mem_addr),   128'(0));
    check("reset_mem_wdata", mem_wdata,        128'(0));
    check("reset_rdata",     128'(dmem_rdata), 128'(0));
    rst = 1'b1;

    // Cold miss: clean allocate, no write-back
    do_access(32'h40, RD_LW, WR_NONE, 32'h0, got, bc);
    check("cold_miss_rdata", 128'(got), 128'(32'h44556677));
    check("cold_miss_busy_cycles", 128'(bc), 128'(1 + (MEM_LAT + 1) + 1));
    check("cold_miss_refill_log", 128'(rd_log.size()), 128'(1));
    check("cold_miss_refill_addr", 128'(rd_log[$]), 128'(28'h4));
    check("cold_miss_no_writeback", 128'(wb_log_addr.size()), 128'(0));

    // Hit table: loads, stores and both-enables, all on the resident line
    rd0 = n_reads; wr0 = n_writes;
    for (int i = 0; i < NV; i++) begin
      do_access(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata, got, bc);
      check($sformatf("vec%0d_rdata", i), 128'(got), 128'(vecs[i].exp_rdata));
      check($sformatf("vec%0d_busy", i), 128'(bc), 128'(0));
    end
    check("hits_no_refill", 128'(n_reads - rd0), 128'(0));
    check("hits_no_writeback", 128'(n_writes - wr0), 128'(0));

    // Dirty eviction of index 4
    do_access(32'hC8, RD_LW, WR_NONE, 32'h0, got, bc);
    check("evict_busy_cycles", 128'(bc), 128'(1 + 2 * (MEM_LAT + 1) + 1));
    check("evict_wb_addr", 128'(wb_log_addr[$]), 128'(28'h4));
    check("evict_wb_data", wb_log_data[$], 128'hDEADBEEF_01020304_ABCD2233_44555A77);
    check("evict_refill_addr", 128'(rd_log[$]), 128'(28'hC));
    check("evict_rdata", 128'(got), 128'(phys_blk[12][95:64]));

    // Randomized traffic over 64 blocks sharing 8 lines
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, wd;
      logic [3:0] rd;
      logic [2:0] wr;
      int op;
      a  = 32'($urandom_range(0, 1023));
      wd = $urandom;
      op = $urandom_range(0, 9);
      rd = RD_NONE;
      wr = WR_NONE;
      if (op < 5) begin
        rd = {1'b1, load_f3[$urandom_range(0, 4)]};
      end else if (op < 9) begin
        wr = {1'b1, 2'($urandom_range(0, 2))};
      end else if (i % 2 == 0) begin
        rd = {1'b1, load_f3[$urandom_range(0, 4)]};
        wr = {1'b1, 2'($urandom_range(0, 2))};
      end
      do_access(a, rd, wr, wd, got, bc);
    end

    // Reset while a refill is outstanding
    for (int i = 0; i < 8; i++) begin prev_blk[i] = res_blk[i]; prev_valid[i] = res_valid[i]; end
    vb = (res_valid[4] && res_blk[4] == 20) ? 36 : 20;
    va = 32'(vb * 16);
    if (res_valid[4] && res_dirty[4]) begin
      exp_wb_addr_q.push_back(28'(res_blk[4]));
      exp_q.push_back(block_of(res_blk[4]));
    end
    exp_rd_q.push_back(28'(vb));
    @(negedge clk);
    dmem_addr = va; dmem_read = RD_LW; dmem_write = WR_NONE;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      #1;
      if (mem_read === 1'b1 && mem_busy === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    check("alloc_reached_before_reset", 128'(found), 128'(1));
    rst = 1'b0;
    @(negedge clk); #1;
    check("mid_reset_mem_read", 128'(mem_read), 128'(0));
    check("mid_reset_busywait", 128'(busywait), 128'(0));
    check("mid_reset_rdata", 128'(dmem_rdata), 128'(0));
    dmem_read = RD_NONE;
    @(negedge clk);
    rst = 1'b1;
    // Dirty data not yet written back is lost; the CPU now sees backing memory
    for (int i = 0; i < 8; i++) begin res_valid[i] = 1'b0; res_dirty[i] = 1'b0; end
    for (int b = 0; b < 64; b++) set_block(b, phys_blk[b]);

    // Every previously resident block must now miss
    for (int i = 0; i < 8; i++) begin
      if (prev_valid[i]) do_access(32'(prev_blk[i] * 16 + 4), RD_LW, WR_NONE, 32'h0, got, bc);
    end
    go_idle();

    check("refill_queue_drained", 128'(exp_rd_q.size()), 128'(0));
    check("writeback_queue_drained", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
